// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths, opcodes, ALU codes, field positions and FSM states for the 18-bit CPU
package cpu_pkg;

  localparam int DATA_W = 18;
  localparam int ADDR_W = 10;
  localparam int SEL_W  = 4;
  localparam int OP_W   = 4;
  localparam int IMM_W  = 6;

  localparam int OP_MSB   = 17;
  localparam int OP_LSB   = 14;
  localparam int RD_MSB   = 13;
  localparam int RD_LSB   = 10;
  localparam int RS_MSB   = 9;
  localparam int RS_LSB   = 6;
  localparam int RT_MSB   = 5;
  localparam int RT_LSB   = 2;
  localparam int IMM_MSB  = 5;
  localparam int ADDR_MSB = 9;

  localparam logic [OP_W-1:0] OP_ADD  = 4'b0000;
  localparam logic [OP_W-1:0] OP_AND  = 4'b0001;
  localparam logic [OP_W-1:0] OP_NAND = 4'b0010;
  localparam logic [OP_W-1:0] OP_NOR  = 4'b0011;
  localparam logic [OP_W-1:0] OP_ADDI = 4'b0100;
  localparam logic [OP_W-1:0] OP_ANDI = 4'b0101;
  localparam logic [OP_W-1:0] OP_LD   = 4'b0110;
  localparam logic [OP_W-1:0] OP_ST   = 4'b0111;
  localparam logic [OP_W-1:0] OP_JUMP = 4'b1000;
  localparam logic [OP_W-1:0] OP_BEQ  = 4'b1001;
  localparam logic [OP_W-1:0] OP_HALT = 4'b1111;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_AND  = 2'b01;
  localparam logic [1:0] ALU_NAND = 2'b10;
  localparam logic [1:0] ALU_NOR  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT
  } state_e;

  function automatic logic [DATA_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
    return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/cpu_instr_decoder.sv
// rtl/cpu_instr_decoder.sv - combinational split of an instruction word into fields and class flags
import cpu_pkg::*;

module cpu_instr_decoder (
  input  logic [DATA_W-1:0] ir,
  output logic [SEL_W-1:0]  rd,
  output logic [SEL_W-1:0]  rs,
  output logic [SEL_W-1:0]  rt,
  output logic [DATA_W-1:0] imm_sext,
  output logic [ADDR_W-1:0] addr10,
  output logic [1:0]        alu_ctrl,
  output logic              is_alu,
  output logic              is_alu_imm,
  output logic              is_ld,
  output logic              is_st,
  output logic              is_jump,
  output logic              is_beq,
  output logic              is_halt,
  output logic              is_illegal
);

  logic [OP_W-1:0] op;

  always_comb begin
    op         = ir[OP_MSB:OP_LSB];
    rd         = ir[RD_MSB:RD_LSB];
    rs         = ir[RS_MSB:RS_LSB];
    rt         = ir[RT_MSB:RT_LSB];
    imm_sext   = sext_imm(ir[IMM_MSB:0]);
    addr10     = ir[ADDR_MSB:0];
    alu_ctrl   = ALU_ADD;
    is_alu     = 1'b0;
    is_alu_imm = 1'b0;
    is_ld      = 1'b0;
    is_st      = 1'b0;
    is_jump    = 1'b0;
    is_beq     = 1'b0;
    is_halt    = 1'b0;
    is_illegal = 1'b0;
    case (op)
      OP_ADD:  begin is_alu = 1'b1; alu_ctrl = ALU_ADD;  end
      OP_AND:  begin is_alu = 1'b1; alu_ctrl = ALU_AND;  end
      OP_NAND: begin is_alu = 1'b1; alu_ctrl = ALU_NAND; end
      OP_NOR:  begin is_alu = 1'b1; alu_ctrl = ALU_NOR;  end
      OP_ADDI: begin is_alu = 1'b1; is_alu_imm = 1'b1; alu_ctrl = ALU_ADD; end
      OP_ANDI: begin is_alu = 1'b1; is_alu_imm = 1'b1; alu_ctrl = ALU_AND; end
      OP_LD:   is_ld      = 1'b1;
      OP_ST:   is_st      = 1'b1;
      OP_JUMP: is_jump    = 1'b1;
      OP_BEQ:  is_beq     = 1'b1;
      OP_HALT: is_halt    = 1'b1;
      default: is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/cpu_control_unit.sv
// rtl/cpu_control_unit.sv - multicycle fetch/decode/execute controller with registered outputs
import cpu_pkg::*;

module cpu_control_unit (
  input  logic              Clock,
  input  logic              Clear_n,
  output logic              InstrReq,
  output logic [ADDR_W-1:0] InstrAddr,
  input  logic              InstrValid,
  input  logic [DATA_W-1:0] InstrData,
  output logic              MemReq,
  output logic              MemWE,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWData,
  input  logic              MemValid,
  input  logic [DATA_W-1:0] MemRData,
  output logic [SEL_W-1:0]  ReadSelect1,
  output logic [SEL_W-1:0]  ReadSelect2,
  input  logic [DATA_W-1:0] ReadData1,
  input  logic [DATA_W-1:0] ReadData2,
  output logic [SEL_W-1:0]  WriteSelect,
  output logic [DATA_W-1:0] WriteData,
  output logic              WriteEnable,
  output logic [DATA_W-1:0] ALU_A,
  output logic [DATA_W-1:0] ALU_B,
  output logic [1:0]        ALUControl,
  input  logic [DATA_W-1:0] ALUResult,
  output logic              Halted,
  output logic              IllegalOp
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] result_q, result_d;

  logic              instr_req_q, instr_req_d;
  logic [ADDR_W-1:0] instr_addr_q, instr_addr_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [SEL_W-1:0]  rsel1_q, rsel1_d;
  logic [SEL_W-1:0]  rsel2_q, rsel2_d;
  logic [SEL_W-1:0]  wsel_q, wsel_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [1:0]        alu_ctrl_q, alu_ctrl_d;
  logic              halted_q, halted_d;
  logic              illegal_q, illegal_d;

  logic [SEL_W-1:0]  dec_rd, dec_rs, dec_rt;
  logic [DATA_W-1:0] dec_imm_sext;
  logic [ADDR_W-1:0] dec_addr10;
  logic [1:0]        dec_alu_ctrl;
  logic dec_alu, dec_alu_imm, dec_ld, dec_st, dec_jump, dec_beq, dec_halt, dec_illegal;
  logic [ADDR_W-1:0] pc_inc;

  // Decoding the next IR lets every state-entry output be registered on the edge that enters it.
  always_comb begin
    ir_d = ir_q;
    if (state_q == ST_FETCH && InstrValid) ir_d = InstrData;
  end

  cpu_instr_decoder u_decoder (
    .ir         (ir_d),
    .rd         (dec_rd),
    .rs         (dec_rs),
    .rt         (dec_rt),
    .imm_sext   (dec_imm_sext),
    .addr10     (dec_addr10),
    .alu_ctrl   (dec_alu_ctrl),
    .is_alu     (dec_alu),
    .is_alu_imm (dec_alu_imm),
    .is_ld      (dec_ld),
    .is_st      (dec_st),
    .is_jump    (dec_jump),
    .is_beq     (dec_beq),
    .is_halt    (dec_halt),
    .is_illegal (dec_illegal)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    pc_inc   = pc_q + 10'd1;
    case (state_q)
      ST_IDLE:  state_d = ST_FETCH;
      ST_FETCH: if (InstrValid) state_d = ST_DECODE;
      ST_DECODE: begin
        a_d = ReadData1;
        b_d = ReadData2;
        if (dec_alu || dec_beq) begin
          state_d = ST_EXEC;
        end else if (dec_ld || dec_st) begin
          state_d = ST_MEM;
        end else if (dec_jump) begin
          pc_d    = dec_addr10;
          state_d = ST_FETCH;
        end else if (dec_halt) begin
          state_d = ST_HALT;
        end else begin
          pc_d    = pc_inc;
          state_d = ST_FETCH;
        end
      end
      ST_EXEC: begin
        if (dec_beq) begin
          pc_d    = (a_q == b_q) ? pc_inc + dec_imm_sext[ADDR_W-1:0] : pc_inc;
          state_d = ST_FETCH;
        end else begin
          result_d = ALUResult;
          state_d  = ST_WB;
        end
      end
      ST_MEM: begin
        if (MemValid) begin
          if (dec_st) begin
            pc_d    = pc_inc;
            state_d = ST_FETCH;
          end else begin
            result_d = MemRData;
            state_d  = ST_WB;
          end
        end
      end
      ST_WB: begin
        pc_d    = pc_inc;
        state_d = ST_FETCH;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are a function of the state being entered, so they are stable for the whole state.
  always_comb begin
    instr_req_d  = 1'b0;
    instr_addr_d = '0;
    mem_req_d    = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = '0;
    mem_wdata_d  = '0;
    rsel1_d      = '0;
    rsel2_d      = '0;
    wsel_d       = '0;
    wdata_d      = '0;
    we_d         = 1'b0;
    alu_a_d      = '0;
    alu_b_d      = '0;
    alu_ctrl_d   = '0;
    halted_d     = 1'b0;
    illegal_d    = 1'b0;
    case (state_d)
      ST_FETCH: begin
        instr_req_d  = 1'b1;
        instr_addr_d = pc_d;
      end
      ST_DECODE: begin
        rsel1_d   = (dec_st || dec_beq) ? dec_rd : dec_rs;
        rsel2_d   = dec_beq ? dec_rs : dec_rt;
        illegal_d = dec_illegal;
      end
      ST_EXEC: begin
        if (!dec_beq) begin
          alu_a_d    = a_d;
          alu_b_d    = dec_alu_imm ? dec_imm_sext : b_d;
          alu_ctrl_d = dec_alu_ctrl;
        end
      end
      ST_MEM: begin
        mem_req_d   = 1'b1;
        mem_we_d    = dec_st;
        mem_addr_d  = dec_addr10;
        mem_wdata_d = a_d;
      end
      ST_WB: begin
        we_d    = 1'b1;
        wsel_d  = dec_rd;
        wdata_d = result_d;
      end
      ST_HALT: halted_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge Clock or negedge Clear_n) begin
    if (!Clear_n) begin
      state_q      <= ST_IDLE;
      pc_q         <= '0;
      ir_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      result_q     <= '0;
      instr_req_q  <= 1'b0;
      instr_addr_q <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      rsel1_q      <= '0;
      rsel2_q      <= '0;
      wsel_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_ctrl_q   <= '0;
      halted_q     <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      a_q          <= a_d;
      b_q          <= b_d;
      result_q     <= result_d;
      instr_req_q  <= instr_req_d;
      instr_addr_q <= instr_addr_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      rsel1_q      <= rsel1_d;
      rsel2_q      <= rsel2_d;
      wsel_q       <= wsel_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_ctrl_q   <= alu_ctrl_d;
      halted_q     <= halted_d;
      illegal_q    <= illegal_d;
    end
  end

  assign InstrReq    = instr_req_q;
  assign InstrAddr   = instr_addr_q;
  assign MemReq      = mem_req_q;
  assign MemWE       = mem_we_q;
  assign MemAddr     = mem_addr_q;
  assign MemWData    = mem_wdata_q;
  assign ReadSelect1 = rsel1_q;
  assign ReadSelect2 = rsel2_q;
  assign WriteSelect = wsel_q;
  assign WriteData   = wdata_q;
  assign WriteEnable = we_q;
  assign ALU_A       = alu_a_q;
  assign ALU_B       = alu_b_q;
  assign ALUControl  = alu_ctrl_q;
  assign Halted      = halted_q;
  assign IllegalOp   = illegal_q;

endmodule
